vga_pixel_fetch: RTL
====================

// Module: vga_pixel_fetch
// PURPOSE
// - Pixel-pipeline stage directly upstream of the VGA output pins; sits between the timing generator and the DAC.
// - Consumes sync/DE/x/y from the timing generator and issues reads to a synchronous RGB332 frame buffer.
// - Emits VGA_HS/VGA_VS/VGA_R/G/B with sync and DE delayed so they line up with the returned pixel data.
// - Shows an IMG_W x IMG_H image at the top-left of 640x480 and fills the rest of the active area with BORDER_RGB.
// PARAMETERS
// - IMG_W       320       image width in source pixels
// - IMG_H       240       image height in source pixels
// - ADDR_W      17        frame-buffer address width; requires IMG_W*IMG_H <= 2**ADDR_W
// - MEM_LAT     1         frame-buffer read latency in cycles (1..4)
// - BORDER_RGB  24'h000040  colour for active pixels outside the image
// PORTS
// - CLK25MHZ    in   1       pixel clock
// - RST_N       in   1       asynchronous reset, active low
// - hs_in       in   1       horizontal sync from timing generator, active low
// - vs_in       in   1       vertical sync from timing generator, active low
// - de_in       in   1       display enable (active area)
// - x_in        in   10      column, 0..639 while de_in
// - y_in        in   10      row, 0..479 while de_in
// - mem_rd      out  1       read strobe
// - mem_addr    out  ADDR_W  read address
// - mem_data    in   8       RGB332 pixel, valid MEM_LAT cycles after mem_rd
// - VGA_HS      out  1       aligned horizontal sync
// - VGA_VS      out  1       aligned vertical sync
// - VGA_R       out  8       red
// - VGA_G       out  8       green
// - VGA_B       out  8       blue
// - frame_start out  1       one-cycle pulse on each vs_in falling edge
// BEHAVIOUR
// - Reset values: VGA_HS=1, VGA_VS=1, VGA_R/G/B=0, mem_rd=0, mem_addr=0, frame_start=0.
// - All delay-line stages reset to the same idle values (sync stages to 1, all others to 0).
// - Two-state FSM:
//   - WAIT_VS (entered at reset): mem_rd is held at 0; the outputs still pass delayed sync, with RGB=0.
//   - WAIT_VS -> RUN on the first vs_in falling edge.
//   - RUN stays in RUN until reset, including a reset asserted mid-frame.
// - In-window condition: win = de_in & x < IMG_W & y < IMG_H, using the effective x/y defined under CONFIGURATION.
// - mem_rd = win registered once. mem_addr is a registered counter, so a read issues 1 cycle after the input pixel.
// - Address counter:
//   - Cleared to 0 on every vs_in falling edge.
//   - Increments by 1 after each read.
//   - Holds its value outside the window.
//   - Never wraps: the last address of a frame is IMG_W*IMG_H-1.
// - Total latency from input to output is L = MEM_LAT + 2 cycles: 1 for the address register, MEM_LAT for memory, 1 for the output register.
// - hs_in, vs_in, de_in and win are each delayed by exactly L cycles.
// - Output colour:
//   - win_d: expand RGB332 to R={r,r,r[2:1]}, G={g,g,g[2:1]}, B={b,b,b,b}.
//   - de_d & !win_d: BORDER_RGB.
//   - !de_d: 0 (blanking).
// - When a vs_in falling edge coincides with an increment, the clear wins.
// - frame_start is registered from the vs_in falling edge; it is not delayed by L.
// CONFIGURATION
// - Macro PIXEL_DOUBLE_EN, defined:
//   - Effective x = x_in>>1 and y = y_in>>1, so each source pixel fills 2x2 screen pixels.
//   - The address increments on odd x_in only.
//   - At the end of a window line where y_in is even, the counter rewinds to that line's start address, kept in a line-base register.
//   - With the defaults, a 320x240 image fills the whole screen.
// - PIXEL_DOUBLE_EN undefined: effective x = x_in and y = y_in, with no rewind, so the image occupies the top-left 320x240.
// STRUCTURE
// - Package vga_pkg:
//   - H_ACTIVE=640 and V_ACTIVE=480.
//   - typedef rgb332_t (packed r[2:0], g[2:0], b[1:0]) and typedef rgb888_t.
//   - function rgb332_to_888.
// - Sub-module vga_delay_line #(WIDTH, DEPTH, RST_VAL): shift register with async reset, used for the sync/DE/win alignment.
// TESTING
// - Reset then an idle frame with vs_in low at t0 -> mem_rd=0 until t0, and frame_start=1 at t0+1 only.
// - In RUN with de_in=1, x=0, y=0 at cycle c -> mem_rd=1 and mem_addr=0 at c+1; RGB from mem_data=8'hE3 appears at c+L as R=FF, G=00, B=FF.
// - Undoubled, row y=1, x=0..319 -> addresses 320..639 in order; x=320..639 give BORDER_RGB=000040.
// - de_in=0 across hs_in pulse -> RGB=0, and VGA_HS equals hs_in delayed by exactly L for MEM_LAT=1 and MEM_LAT=3.
// - PIXEL_DOUBLE_EN: rows y=0 and y=1 both read addresses 0,0,1,1,...,319,319; row y=2 starts at 320; the last read of the frame is 76799.
// - Assert RST_N mid-line -> outputs return to reset values immediately, and no mem_rd occurs until the next vs_in falling edge.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel-fetch path.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic {
    WAIT_VS = 1'b0,
    RUN     = 1'b1
  } fetch_state_e;

  // Replicate the high bits so full-scale 332 maps to full-scale 888.
  function automatic rgb888_t rgb332_to_888(input rgb332_t p);
    rgb888_t o;
    o.r = {p.r, p.r, p.r[2:1]};
    o.g = {p.g, p.g, p.g[2:1]};
    o.b = {p.b, p.b, p.b, p.b};
    return o;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous reset to a caller-chosen idle value.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Next value of every stage: new sample enters stage 0, the rest shift down.
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; all stages reset to the idle value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage between the VGA timing generator and the DAC pins.
// Reads an RGB332 frame buffer and re-aligns sync/DE with the returned data.
// Optional macro PIXEL_DOUBLE_EN: each source pixel covers 2x2 screen pixels.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int          IMG_W      = 320,
  parameter int          IMG_H      = 240,
  parameter int          ADDR_W     = 17,
  parameter int          MEM_LAT    = 1,
  parameter logic [23:0] BORDER_RGB = 24'h000040
) (
  input  logic              CLK25MHZ,
  input  logic              RST_N,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              de_in,
  input  logic [9:0]        x_in,
  input  logic [9:0]        y_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              frame_start,
  output fetch_state_e      dbg_state
);

  localparam logic [10:0]       W_LIM     = 11'(IMG_W);
  localparam logic [10:0]       H_LIM     = 11'(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  fetch_state_e      state_q, state_d;
  logic              vs_prev_q, frame_start_q, frame_start_d;
  logic              mem_rd_q, mem_rd_d;
  logic              inc_q, inc_d, rewind_q, rewind_d, line_end_q, line_end_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, line_base_q, line_base_d, addr_next;
  logic              hs_q, hs_d, vs_q, vs_d;
  rgb888_t           rgb_q, rgb_d;

  logic [9:0]        x_eff, y_eff;
  logic              win, vs_fall, pix_inc, pix_line_end, pix_rewind;
  logic              hs_dl, vs_dl, de_dl, win_dl;

  // Input-side decode: effective coordinates, window test and counter controls.
  always_comb begin
`ifdef PIXEL_DOUBLE_EN
    x_eff        = {1'b0, x_in[9:1]};
    y_eff        = {1'b0, y_in[9:1]};
    pix_inc      = x_in[0];
    pix_line_end = x_in[0] & ({1'b0, x_eff} == W_LIM - 11'd1);
    pix_rewind   = pix_line_end & ~y_in[0];
`else
    x_eff        = x_in;
    y_eff        = y_in;
    pix_inc      = 1'b1;
    pix_line_end = 1'b0;
    pix_rewind   = 1'b0;
`endif
    win     = de_in & ({1'b0, x_eff} < W_LIM) & ({1'b0, y_eff} < H_LIM);
    vs_fall = vs_prev_q & ~vs_in;
  end

  // Sync, DE and window ride alongside the memory read so they meet the data.
  vga_delay_line #(
    .WIDTH  (4),
    .DEPTH  (MEM_LAT + 1),
    .RST_VAL(4'b1100)
  ) u_align (
    .clk  (CLK25MHZ),
    .rst_n(RST_N),
    .din  ({hs_in, vs_in, de_in, win}),
    .dout ({hs_dl, vs_dl, de_dl, win_dl})
  );

  // Next-state logic: FSM, read strobe, address counter with line rewind, output colour.
  always_comb begin
    state_d       = state_q;
    frame_start_d = vs_fall;
    mem_rd_d      = win & (state_q == RUN);
    inc_d         = pix_inc;
    rewind_d      = pix_rewind;
    line_end_d    = pix_line_end;
    mem_addr_d    = mem_addr_q;
    line_base_d   = line_base_q;
    addr_next     = (mem_addr_q == LAST_ADDR) ? mem_addr_q : mem_addr_q + 1'b1;
    hs_d          = hs_dl;
    vs_d          = vs_dl;
    rgb_d         = '0;

    if (state_q == WAIT_VS && vs_fall) begin
      state_d = RUN;
    end

    // A frame restart beats any pending increment or rewind.
    if (vs_fall) begin
      mem_addr_d  = '0;
      line_base_d = '0;
    end else if (mem_rd_q && inc_q) begin
      if (rewind_q) begin
        mem_addr_d = line_base_q;
      end else begin
        mem_addr_d = addr_next;
        if (line_end_q) begin
          line_base_d = addr_next;
        end
      end
    end

    if (state_q == RUN) begin
      if (win_dl) begin
        rgb_d = rgb332_to_888(rgb332_t'(mem_data));
      end else if (de_dl) begin
        rgb_d = rgb888_t'(BORDER_RGB);
      end
    end
  end

  // All state, with idle values on reset (sync high, everything else low).
  always_ff @(posedge CLK25MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= WAIT_VS;
      vs_prev_q     <= 1'b1;
      frame_start_q <= 1'b0;
      mem_rd_q      <= 1'b0;
      inc_q         <= 1'b0;
      rewind_q      <= 1'b0;
      line_end_q    <= 1'b0;
      mem_addr_q    <= '0;
      line_base_q   <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      vs_prev_q     <= vs_in;
      frame_start_q <= frame_start_d;
      mem_rd_q      <= mem_rd_d;
      inc_q         <= inc_d;
      rewind_q      <= rewind_d;
      line_end_q    <= line_end_d;
      mem_addr_q    <= mem_addr_d;
      line_base_q   <= line_base_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      rgb_q         <= rgb_d;
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign frame_start = frame_start_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_R       = rgb_q.r;
  assign VGA_G       = rgb_q.g;
  assign VGA_B       = rgb_q.b;
  assign dbg_state   = state_q;

endmodule
